// File: rtl/int_iq_select_wakeup.sv
// int_iq_select_wakeup
//   Integer issue queue core. Dispatched INT ops wait in a collapsing queue
//   (index 0 = oldest). Their sources are woken by the registered issue-tag
//   broadcast and by external writeback tags. Up to two ready ops issue per
//   cycle, oldest first.
// Ports
//   clk, rst_n             clock, synchronous active-low reset
//   flush                  squash all entries and issue outputs
//   rr_stall               register read busy: hold issue outputs, no select
//   disp{0,1}_*            dispatch slots (slot0 older), disp_ready back-pressure
//   ext_wb_valid/ext_wb_rd external wakeup tags (port 0 in the low bits)
//   iss{0,1}_*             registered issue outputs and rd broadcast
module int_iq_select_wakeup #(
  parameter int DEPTH     = 8,
  parameter int PRF_W     = 6,
  parameter int PAYLOAD_W = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 rr_stall,
  input  logic                 disp0_valid,
  input  logic [PRF_W-1:0]     disp0_rs1,
  input  logic                 disp0_rs1_rdy,
  input  logic [PRF_W-1:0]     disp0_rs2,
  input  logic                 disp0_rs2_rdy,
  input  logic [PRF_W-1:0]     disp0_rd,
  input  logic                 disp0_rd_valid,
  input  logic [PAYLOAD_W-1:0] disp0_payload,
  input  logic                 disp1_valid,
  input  logic [PRF_W-1:0]     disp1_rs1,
  input  logic                 disp1_rs1_rdy,
  input  logic [PRF_W-1:0]     disp1_rs2,
  input  logic                 disp1_rs2_rdy,
  input  logic [PRF_W-1:0]     disp1_rd,
  input  logic                 disp1_rd_valid,
  input  logic [PAYLOAD_W-1:0] disp1_payload,
  output logic                 disp_ready,
  input  logic [1:0]           ext_wb_valid,
  input  logic [2*PRF_W-1:0]   ext_wb_rd,
  output logic                 iss0_valid,
  output logic [PAYLOAD_W-1:0] iss0_payload,
  output logic                 iss0_rd_valid,
  output logic [PRF_W-1:0]     iss0_rd,
  output logic                 iss1_valid,
  output logic [PAYLOAD_W-1:0] iss1_payload,
  output logic                 iss1_rd_valid,
  output logic [PRF_W-1:0]     iss1_rd
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic                 valid;
    logic [PRF_W-1:0]     rs1;
    logic                 rs1_rdy;
    logic [PRF_W-1:0]     rs2;
    logic                 rs2_rdy;
    logic [PRF_W-1:0]     rd;
    logic                 rd_valid;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  entry_t             q     [DEPTH];
  entry_t             q_upd [DEPTH];
  entry_t             q_nxt [DEPTH];
  entry_t             new0, new1;
  logic [DEPTH-1:0]   entry_rdy;
  logic [DEPTH-1:0]   sel_mask;
  logic               found0, found1;
  logic [IDX_W-1:0]   idx0, idx1;
  logic [CNT_W-1:0]   count, count_nxt;
  logic               disp0_fire, disp1_fire;

  // Wake vector: registered issue broadcast plus external writeback.
  logic [3:0]         w_vld;
  logic [4*PRF_W-1:0] w_tags;
  assign w_vld  = {ext_wb_valid, iss1_rd_valid, iss0_rd_valid};
  assign w_tags = {ext_wb_rd, iss1_rd, iss0_rd};

  function automatic logic woken(input logic [PRF_W-1:0] tag,
                                 input logic [3:0] vld,
                                 input logic [4*PRF_W-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < 4; k++)
      if (vld[k] && (tags[k*PRF_W +: PRF_W] == tag)) hit = 1'b1;
    return hit;
  endfunction

  assign disp_ready = (count <= CNT_W'(DEPTH - 2));
  assign disp0_fire = disp_ready & disp0_valid & ~flush;
  assign disp1_fire = disp_ready & disp1_valid & ~flush;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      q_upd[i]         = q[i];
      q_upd[i].rs1_rdy = q[i].rs1_rdy | woken(q[i].rs1, w_vld, w_tags);
      q_upd[i].rs2_rdy = q[i].rs2_rdy | woken(q[i].rs2, w_vld, w_tags);
      entry_rdy[i]     = q[i].valid & q_upd[i].rs1_rdy & q_upd[i].rs2_rdy;
    end
  end

  // Dispatched sources see the same wake vector so no wakeup slips past.
  always_comb begin
    new0 = '{valid: 1'b1, rs1: disp0_rs1,
             rs1_rdy: disp0_rs1_rdy | woken(disp0_rs1, w_vld, w_tags),
             rs2: disp0_rs2,
             rs2_rdy: disp0_rs2_rdy | woken(disp0_rs2, w_vld, w_tags),
             rd: disp0_rd, rd_valid: disp0_rd_valid, payload: disp0_payload};
    new1 = '{valid: 1'b1, rs1: disp1_rs1,
             rs1_rdy: disp1_rs1_rdy | woken(disp1_rs1, w_vld, w_tags),
             rs2: disp1_rs2,
             rs2_rdy: disp1_rs2_rdy | woken(disp1_rs2, w_vld, w_tags),
             rd: disp1_rd, rd_valid: disp1_rd_valid, payload: disp1_payload};
  end

  // Oldest-first pick of up to two ready entries.
  always_comb begin
    found0   = 1'b0;
    found1   = 1'b0;
    idx0     = '0;
    idx1     = '0;
    sel_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!rr_stall && !flush && entry_rdy[i]) begin
        if (!found0) begin
          found0      = 1'b1;
          idx0        = IDX_W'(i);
          sel_mask[i] = 1'b1;
        end else if (!found1) begin
          found1      = 1'b1;
          idx1        = IDX_W'(i);
          sel_mask[i] = 1'b1;
        end
      end
    end
  end

  // Collapse survivors toward index 0, then append new ops behind them.
  always_comb begin
    count_nxt = '0;
    for (int i = 0; i < DEPTH; i++) q_nxt[i] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_upd[i].valid && !sel_mask[i]) begin
        q_nxt[count_nxt[IDX_W-1:0]] = q_upd[i];
        count_nxt = count_nxt + 1'b1;
      end
    end
    if (disp0_fire && count_nxt < CNT_W'(DEPTH)) begin
      q_nxt[count_nxt[IDX_W-1:0]] = new0;
      count_nxt = count_nxt + 1'b1;
    end
    if (disp1_fire && count_nxt < CNT_W'(DEPTH)) begin
      q_nxt[count_nxt[IDX_W-1:0]] = new1;
      count_nxt = count_nxt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      count         <= '0;
      iss0_valid    <= 1'b0;
      iss0_payload  <= '0;
      iss0_rd_valid <= 1'b0;
      iss0_rd       <= '0;
      iss1_valid    <= 1'b0;
      iss1_payload  <= '0;
      iss1_rd_valid <= 1'b0;
      iss1_rd       <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) q[i] <= q_nxt[i];
      count <= count_nxt;
      if (!rr_stall) begin
        iss0_valid    <= found0;
        iss0_payload  <= found0 ? q[idx0].payload : '0;
        iss0_rd_valid <= found0 & q[idx0].rd_valid;
        iss0_rd       <= found0 ? q[idx0].rd : '0;
        iss1_valid    <= found1;
        iss1_payload  <= found1 ? q[idx1].payload : '0;
        iss1_rd_valid <= found1 & q[idx1].rd_valid;
        iss1_rd       <= found1 ? q[idx1].rd : '0;
      end
    end
  end

endmodule

// File: tb/tb_int_iq_select_wakeup.sv
module tb_int_iq_select_wakeup;

  logic        clk = 1'b0;
  logic        rst_n, flush, rr_stall;
  logic        disp0_valid, disp0_rs1_rdy, disp0_rs2_rdy, disp0_rd_valid;
  logic [5:0]  disp0_rs1, disp0_rs2, disp0_rd;
  logic [63:0] disp0_payload;
  logic        disp1_valid, disp1_rs1_rdy, disp1_rs2_rdy, disp1_rd_valid;
  logic [5:0]  disp1_rs1, disp1_rs2, disp1_rd;
  logic [63:0] disp1_payload;
  logic        disp_ready;
  logic [1:0]  ext_wb_valid;
  logic [11:0] ext_wb_rd;
  logic        iss0_valid, iss0_rd_valid, iss1_valid, iss1_rd_valid;
  logic [63:0] iss0_payload, iss1_payload;
  logic [5:0]  iss0_rd, iss1_rd;

  int n_assert = 0;
  int n_fail   = 0;

  int_iq_select_wakeup dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .rr_stall(rr_stall),
    .disp0_valid(disp0_valid), .disp0_rs1(disp0_rs1), .disp0_rs1_rdy(disp0_rs1_rdy),
    .disp0_rs2(disp0_rs2), .disp0_rs2_rdy(disp0_rs2_rdy), .disp0_rd(disp0_rd),
    .disp0_rd_valid(disp0_rd_valid), .disp0_payload(disp0_payload),
    .disp1_valid(disp1_valid), .disp1_rs1(disp1_rs1), .disp1_rs1_rdy(disp1_rs1_rdy),
    .disp1_rs2(disp1_rs2), .disp1_rs2_rdy(disp1_rs2_rdy), .disp1_rd(disp1_rd),
    .disp1_rd_valid(disp1_rd_valid), .disp1_payload(disp1_payload),
    .disp_ready(disp_ready), .ext_wb_valid(ext_wb_valid), .ext_wb_rd(ext_wb_rd),
    .iss0_valid(iss0_valid), .iss0_payload(iss0_payload),
    .iss0_rd_valid(iss0_rd_valid), .iss0_rd(iss0_rd),
    .iss1_valid(iss1_valid), .iss1_payload(iss1_payload),
    .iss1_rd_valid(iss1_rd_valid), .iss1_rd(iss1_rd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_d0(input logic [5:0] rs1, input logic r1, input logic [5:0] rd,
                        input logic rdv, input logic [63:0] pl);
    disp0_valid = 1'b1; disp0_rs1 = rs1; disp0_rs1_rdy = r1;
    disp0_rs2 = 6'd1; disp0_rs2_rdy = 1'b1;
    disp0_rd = rd; disp0_rd_valid = rdv; disp0_payload = pl;
  endtask

  task automatic set_d1(input logic [5:0] rs1, input logic r1, input logic [5:0] rd,
                        input logic rdv, input logic [63:0] pl);
    disp1_valid = 1'b1; disp1_rs1 = rs1; disp1_rs1_rdy = r1;
    disp1_rs2 = 6'd1; disp1_rs2_rdy = 1'b1;
    disp1_rd = rd; disp1_rd_valid = rdv; disp1_payload = pl;
  endtask

  task automatic clr_disp();
    disp0_valid = 1'b0; disp0_rs1 = '0; disp0_rs1_rdy = 1'b0; disp0_rs2 = '0;
    disp0_rs2_rdy = 1'b0; disp0_rd = '0; disp0_rd_valid = 1'b0; disp0_payload = '0;
    disp1_valid = 1'b0; disp1_rs1 = '0; disp1_rs1_rdy = 1'b0; disp1_rs2 = '0;
    disp1_rs2_rdy = 1'b0; disp1_rd = '0; disp1_rd_valid = 1'b0; disp1_payload = '0;
  endtask

  // Upstream must never dispatch into a queue that is not ready.
  always @(negedge clk)
    if (rst_n && !flush && !disp_ready && (disp0_valid || disp1_valid))
      $error("FAIL dispatch_while_not_ready observed=1 expected=0");

  initial begin
    rst_n = 1'b0; flush = 1'b0; rr_stall = 1'b0;
    ext_wb_valid = '0; ext_wb_rd = '0;
    clr_disp();
    tick(); tick();

    // Reset state
    chk("rst_iss0_valid", iss0_valid, 0);
    chk("rst_iss1_valid", iss1_valid, 0);
    chk("rst_iss0_rd_valid", iss0_rd_valid, 0);
    chk("rst_iss0_rd", iss0_rd, 0);
    chk("rst_iss0_payload", iss0_payload, 0);
    chk("rst_disp_ready", disp_ready, 1);
    chk("rst_count", dut.count, 0);
    rst_n = 1'b1;

    // 1: two ready ops issue two cycles after dispatch
    set_d0(6'd2, 1'b1, 6'd5, 1'b1, 64'hA1);
    set_d1(6'd3, 1'b1, 6'd6, 1'b1, 64'hA2);
    tick(); clr_disp();
    chk("t1_no_early_issue", iss0_valid, 0);
    chk("t1_count2", dut.count, 2);
    tick();
    chk("t1_iss0_valid", iss0_valid, 1);
    chk("t1_iss0_rd", iss0_rd, 5);
    chk("t1_iss0_payload", iss0_payload, 64'hA1);
    chk("t1_iss1_valid", iss1_valid, 1);
    chk("t1_iss1_rd", iss1_rd, 6);
    chk("t1_iss1_rd_valid", iss1_rd_valid, 1);
    chk("t1_count0", dut.count, 0);
    tick();
    chk("t1_idle0", iss0_valid, 0);
    chk("t1_idle1", iss1_valid, 0);

    // 2: back-to-back wakeup through the issue broadcast
    set_d0(6'd2, 1'b1, 6'd7, 1'b1, 64'h201);
    set_d1(6'd7, 1'b0, 6'd8, 1'b1, 64'h202);
    tick(); clr_disp();
    tick();
    chk("t2_a_rd", iss0_rd, 7);
    chk("t2_a_valid", iss0_valid, 1);
    chk("t2_b_not_yet", iss1_valid, 0);
    tick();
    chk("t2_b_valid", iss0_valid, 1);
    chk("t2_b_payload", iss0_payload, 64'h202);
    chk("t2_b_slot1_empty", iss1_valid, 0);
    tick();
    chk("t2_idle", iss0_valid, 0);

    // 3: fill with unready ops; entries 2 and 5 wait on tag 40
    set_d0(6'd20, 1'b0, 6'd10, 1'b1, 64'h300);
    set_d1(6'd21, 1'b0, 6'd11, 1'b1, 64'h301);
    tick();
    set_d0(6'd40, 1'b0, 6'd12, 1'b1, 64'h302);
    set_d1(6'd23, 1'b0, 6'd13, 1'b1, 64'h303);
    tick();
    set_d0(6'd24, 1'b0, 6'd14, 1'b1, 64'h304);
    set_d1(6'd40, 1'b0, 6'd15, 1'b1, 64'h305);
    tick(); clr_disp();
    chk("t3_count6", dut.count, 6);
    chk("t3_ready_at6", disp_ready, 1);
    chk("t3_nothing_issued", iss0_valid, 0);
    set_d0(6'd26, 1'b0, 6'd16, 1'b1, 64'h306);
    tick(); clr_disp();
    chk("t3_count7", dut.count, 7);
    chk("t3_not_ready_at7", disp_ready, 0);
    ext_wb_valid = 2'b01; ext_wb_rd = {6'd0, 6'd40};
    tick();
    ext_wb_valid = 2'b00; ext_wb_rd = '0;
    chk("t3_iss0_payload", iss0_payload, 64'h302);
    chk("t3_iss1_payload", iss1_payload, 64'h305);
    chk("t3_iss1_valid", iss1_valid, 1);
    chk("t3_count5", dut.count, 5);
    chk("t3_ready_back", disp_ready, 1);
    tick();
    chk("t3_rest_wait", iss0_valid, 0);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("t3_flush_count", dut.count, 0);

    // 4: stall holds issue outputs, remaining op issues on release
    set_d0(6'd2, 1'b1, 6'd21, 1'b1, 64'h401);
    set_d1(6'd2, 1'b1, 6'd22, 1'b1, 64'h402);
    tick(); clr_disp();
    set_d0(6'd2, 1'b1, 6'd23, 1'b0, 64'h403);
    tick(); clr_disp();
    chk("t4_iss0_payload", iss0_payload, 64'h401);
    chk("t4_iss1_payload", iss1_payload, 64'h402);
    chk("t4_count1", dut.count, 1);
    rr_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t4_hold_iss0_payload", iss0_payload, 64'h401);
      chk("t4_hold_iss1_payload", iss1_payload, 64'h402);
      chk("t4_hold_iss0_valid", iss0_valid, 1);
      chk("t4_hold_count", dut.count, 1);
    end
    rr_stall = 1'b0;
    tick();
    chk("t4_rel_iss0_payload", iss0_payload, 64'h403);
    chk("t4_rel_iss0_valid", iss0_valid, 1);
    chk("t4_rel_no_rd_valid", iss0_rd_valid, 0);
    chk("t4_rel_iss1_valid", iss1_valid, 0);
    tick();
    chk("t4_idle", iss0_valid, 0);

    // 5: flush with four entries and live issue outputs
    set_d0(6'd50, 1'b0, 6'd33, 1'b1, 64'h503);
    set_d1(6'd50, 1'b0, 6'd34, 1'b1, 64'h504);
    tick();
    set_d0(6'd50, 1'b0, 6'd35, 1'b1, 64'h505);
    set_d1(6'd50, 1'b0, 6'd36, 1'b1, 64'h506);
    tick();
    set_d0(6'd2, 1'b1, 6'd31, 1'b1, 64'h501);
    set_d1(6'd2, 1'b1, 6'd32, 1'b1, 64'h502);
    tick(); clr_disp();
    chk("t5_count6", dut.count, 6);
    tick();
    chk("t5_live_iss0", iss0_payload, 64'h501);
    chk("t5_live_iss1", iss1_payload, 64'h502);
    chk("t5_count4", dut.count, 4);
    flush = 1'b1;
    set_d0(6'd2, 1'b1, 6'd37, 1'b1, 64'h507);
    ext_wb_valid = 2'b01; ext_wb_rd = {6'd0, 6'd50};
    tick();
    flush = 1'b0; clr_disp();
    chk("t5_flush_iss0_valid", iss0_valid, 0);
    chk("t5_flush_iss1_valid", iss1_valid, 0);
    chk("t5_flush_rd_valid", iss0_rd_valid, 0);
    chk("t5_flush_count", dut.count, 0);
    chk("t5_flush_ready", disp_ready, 1);
    tick();
    ext_wb_valid = 2'b00; ext_wb_rd = '0;
    chk("t5_no_stale_iss0", iss0_valid, 0);
    chk("t5_no_stale_iss1", iss1_valid, 0);

    // 6: issue 2 and dispatch 2 at count 6; new ops stay youngest
    set_d0(6'd61, 1'b0, 6'd41, 1'b1, 64'h601);
    set_d1(6'd61, 1'b0, 6'd42, 1'b1, 64'h602);
    tick();
    set_d0(6'd60, 1'b0, 6'd43, 1'b1, 64'h603);
    set_d1(6'd60, 1'b0, 6'd44, 1'b1, 64'h604);
    tick();
    set_d0(6'd60, 1'b0, 6'd45, 1'b1, 64'h605);
    set_d1(6'd60, 1'b0, 6'd46, 1'b1, 64'h606);
    tick();
    chk("t6_count6", dut.count, 6);
    chk("t6_ready6", disp_ready, 1);
    set_d0(6'd60, 1'b0, 6'd47, 1'b1, 64'h607);
    set_d1(6'd60, 1'b0, 6'd48, 1'b1, 64'h608);
    ext_wb_valid = 2'b01; ext_wb_rd = {6'd0, 6'd61};
    tick(); clr_disp();
    chk("t6_iss0_r0", iss0_payload, 64'h601);
    chk("t6_iss1_r1", iss1_payload, 64'h602);
    chk("t6_count_stays6", dut.count, 6);
    ext_wb_valid = 2'b10; ext_wb_rd = {6'd60, 6'd0};
    tick();
    ext_wb_valid = 2'b00; ext_wb_rd = '0;
    chk("t6_iss0_u0", iss0_payload, 64'h603);
    chk("t6_iss1_u1", iss1_payload, 64'h604);
    chk("t6_count4", dut.count, 4);
    tick();
    chk("t6_iss0_u2", iss0_payload, 64'h605);
    chk("t6_iss1_u3", iss1_payload, 64'h606);
    tick();
    chk("t6_iss0_n0", iss0_payload, 64'h607);
    chk("t6_iss1_n1", iss1_payload, 64'h608);
    chk("t6_iss1_rd", iss1_rd, 48);
    chk("t6_count0", dut.count, 0);
    tick();
    chk("t6_idle", iss0_valid, 0);

    // Reset mid-operation drops in-flight work
    set_d0(6'd2, 1'b1, 6'd9, 1'b1, 64'h701);
    tick(); clr_disp();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst2_count", dut.count, 0);
    chk("rst2_iss0_valid", iss0_valid, 0);
    tick();
    chk("rst2_no_issue", iss0_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
